// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int BURST_DEF  = 8;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Byte-offset width of one block (BURST words of two bytes).
  localparam int BLK_OFF_W = $clog2(2 * BURST_DEF);

  // Requester identities, also the encoding of the round-robin flop.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    I_FILL,
    D_FILL,
    D_WR
  } arb_state_e;

  function automatic int blk_off_w(input int burst);
    return $clog2(2 * burst);
  endfunction

  function automatic int cnt_w(input int burst);
    return $clog2(burst);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-side, D-side and memory signals around mem_arbiter.
// slave: the arbiter's view; master: the caches and memory around it.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int BURST  = BURST_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int CNT_W = cnt_w(BURST);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_busy;
  logic [DATA_W-1:0] i_data;
  logic              i_vld;
  logic [CNT_W-1:0]  i_word;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_busy;
  logic [DATA_W-1:0] d_data;
  logic              d_vld;
  logic [CNT_W-1:0]  d_word;
  logic              d_done;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvld;

  modport slave (
    input  i_req, i_addr,
    output i_busy, i_data, i_vld, i_word, i_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_busy, d_data, d_vld, d_word, d_done,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvld
  );

  modport master (
    output i_req, i_addr,
    input  i_busy, i_data, i_vld, i_word, i_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_busy, d_data, d_vld, d_word, d_done,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_rvld
  );

endinterface

// File: rtl/arb_burst_ctr.sv
// Issue/receive counter pair for one block fill. The issue counter stops
// after BURST issues (issue_done); recv_last flags the final return word.
module arb_burst_ctr #(
  parameter int BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       issue,
  input  logic                       recv,
  output logic [$clog2(BURST)-1:0]   k,
  output logic [$clog2(BURST)-1:0]   r,
  output logic                       issue_done,
  output logic                       recv_last
);
  localparam int CNT_W = $clog2(BURST);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

  // Issue counter: advances per issue, parks on the last index once done.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all flops so every register sees
    // the pre-edge value of every other register, independent of order.
    if (rst) begin
      k          <= '0;
      issue_done <= 1'b0;
    end else if (clr) begin
      k          <= '0;
      issue_done <= 1'b0;
    end else if (issue && !issue_done) begin
      if (k == LAST) issue_done <= 1'b1;
      else           k <= k + CNT_W'(1);
    end
  end

  // Receive counter: advances on every returned word of the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r <= '0;
    else if (clr)  r <= '0;
    else if (recv) r <= r + CNT_W'(1);
  end

  assign recv_last = (r == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one pipelined single-port memory between the I-cache and
// D-cache miss handlers: 8-word block fills for either side and single-word
// write-throughs for D. All state and outputs are registered.
// Build option ARB_RR_EN: round-robin on simultaneous requests instead of
// fixed D priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST  = BURST_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = cnt_w(BURST);
  localparam int OFF_W = blk_off_w(BURST);

  arb_state_e        state;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  k;
  logic [CNT_W-1:0]  r;
  logic              issue_done;
  logic              recv_last;
  logic              fill;
  logic              grant_d;
  logic              tie_to_d;
  logic [ADDR_W-1:0] blk_addr;

  assign fill     = (state == I_FILL) || (state == D_FILL);
  // Block-aligned base with the issue index as word offset; never carries.
  assign blk_addr = {base[ADDR_W-1:OFF_W], k, 1'b0};

  arb_burst_ctr #(.BURST(BURST)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == IDLE),
    .issue      (fill),
    .recv       (fill && bus.mem_rvld),
    .k          (k),
    .r          (r),
    .issue_done (issue_done),
    .recv_last  (recv_last)
  );

`ifdef ARB_RR_EN
  logic last_win;

  // Remember the winner of the last contested grant; the next tie goes the other way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_win <= REQ_I;
    else if (state == IDLE && bus.i_req && bus.d_req)
      last_win <= grant_d ? REQ_D : REQ_I;
  end

  assign tie_to_d = (last_win == REQ_I);
`else
  assign tie_to_d = 1'b1;
`endif

  assign grant_d = bus.d_req && (!bus.i_req || tie_to_d);

  // Transaction sequencer: grant in IDLE, then fill or write-through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      base          <= '0;
      wdata         <= '0;
      bus.i_busy    <= 1'b0;
      bus.i_data    <= '0;
      bus.i_vld     <= 1'b0;
      bus.i_word    <= '0;
      bus.i_done    <= 1'b0;
      bus.d_busy    <= 1'b0;
      bus.d_data    <= '0;
      bus.d_vld     <= 1'b0;
      bus.d_word    <= '0;
      bus.d_done    <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      // Single-cycle pulses default low and are raised only where needed.
      bus.i_vld  <= 1'b0;
      bus.i_done <= 1'b0;
      bus.d_vld  <= 1'b0;
      bus.d_done <= 1'b0;

      case (state)
        IDLE: begin
          bus.mem_en <= 1'b0;
          bus.mem_wr <= 1'b0;
          bus.i_busy <= 1'b0;
          bus.d_busy <= 1'b0;
          if (grant_d) begin
            base       <= bus.d_addr;
            wdata      <= bus.d_wdata;
            bus.d_busy <= 1'b1;
            state      <= bus.d_we ? D_WR : D_FILL;
          end else if (bus.i_req) begin
            base       <= bus.i_addr;
            bus.i_busy <= 1'b1;
            state      <= I_FILL;
          end
        end

        I_FILL, D_FILL: begin
          bus.mem_en <= !issue_done;
          bus.mem_wr <= 1'b0;
          if (!issue_done) bus.mem_addr <= blk_addr;
          if (bus.mem_rvld) begin
            if (state == I_FILL) begin
              bus.i_data <= bus.mem_rdata;
              bus.i_vld  <= 1'b1;
              bus.i_word <= r;
              bus.i_done <= recv_last;
            end else begin
              bus.d_data <= bus.mem_rdata;
              bus.d_vld  <= 1'b1;
              bus.d_word <= r;
              bus.d_done <= recv_last;
            end
            if (recv_last) state <= IDLE;
          end
        end

        D_WR: begin
          // First cycle strobes the write; the strobe itself marks the second.
          if (!bus.mem_en) begin
            bus.mem_en    <= 1'b1;
            bus.mem_wr    <= 1'b1;
            bus.mem_addr  <= base;
            bus.mem_wdata <= wdata;
          end else begin
            bus.mem_en <= 1'b0;
            bus.mem_wr <= 1'b0;
            bus.d_done <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-stage pipelined memory model
// returning (address ^ 0xA5A5) for every read.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic [2:0]  word;
    logic [15:0] data;
    logic        done;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: fixed read latency, cleared by the shared reset.
  logic [3:0]       pv;
  logic [3:0][15:0] pa;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      pa <= '0;
    end else begin
      pv <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
      pa <= {pa[2:0], bus.mem_addr};
    end
  end
  assign bus.mem_rvld  = pv[3];
  assign bus.mem_rdata = pa[3] ^ 16'hA5A5;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int overlap = 0;
  int i_busy_n, d_busy_n;

  logic [15:0] rd_addrs[$];
  int          rd_cyc[$];
  logic [15:0] wr_addrs[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  beat_t       i_beats[$];
  beat_t       d_beats[$];
  bit          done_side[$];
  int          done_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rd_addrs.delete(); rd_cyc.delete();
    wr_addrs.delete(); wr_data.delete(); wr_cyc.delete();
    i_beats.delete(); d_beats.delete();
    done_side.delete(); done_cyc.delete();
    i_busy_n = 0;
    d_busy_n = 0;
  endtask

  // Record one cycle of DUT outputs (called just after a falling edge).
  task automatic sample();
    cyc++;
    if (bus.mem_en && !bus.mem_wr) begin
      rd_addrs.push_back(bus.mem_addr);
      rd_cyc.push_back(cyc);
    end
    if (bus.mem_en && bus.mem_wr) begin
      wr_addrs.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (bus.i_vld) i_beats.push_back({bus.i_word, bus.i_data, bus.i_done});
    if (bus.d_vld) d_beats.push_back({bus.d_word, bus.d_data, bus.d_done});
    if (bus.i_done) begin done_side.push_back(1'b0); done_cyc.push_back(cyc); end
    if (bus.d_done) begin done_side.push_back(1'b1); done_cyc.push_back(cyc); end
    if (bus.i_busy && bus.d_busy) overlap++;
    if (bus.i_busy) i_busy_n++;
    if (bus.d_busy) d_busy_n++;
  endtask

  // Act as both requesters until n_done done pulses are seen. Each side drops
  // its request on its done, except that the first i_keep I dones keep i_req.
  task automatic serve(input string tag, input int n_done, input int i_keep, input int budget);
    int got    = 0;
    int i_seen = 0;
    int t      = 0;
    while (got < n_done && t < budget) begin
      @(negedge clk);
      t++;
      sample();
      if (bus.d_done) begin
        got++;
        bus.d_req = 1'b0;
      end
      if (bus.i_done) begin
        got++;
        i_seen++;
        if (i_seen > i_keep) bus.i_req = 1'b0;
      end
    end
    check({tag, "_dones"}, got, n_done);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
    end
  endtask

  function automatic int n_dones(input bit side);
    int n = 0;
    foreach (done_side[j]) if (done_side[j] == side) n++;
    return n;
  endfunction

  // Compare one recorded 8-word burst against the block it should cover.
  task automatic check_burst(input string tag, input bit side_d, input logic [15:0] blk,
                             input int rf, input int bf);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] a;
      logic [15:0] ra;
      beat_t       b;
      a  = blk + 16'(2 * k);
      ra = 'x;
      b  = 'x;
      if (rf + k < rd_addrs.size()) ra = rd_addrs[rf + k];
      if (side_d && bf + k < d_beats.size()) b = d_beats[bf + k];
      if (!side_d && bf + k < i_beats.size()) b = i_beats[bf + k];
      check($sformatf("%s_addr%0d", tag, k), 32'(ra), 32'(a));
      check($sformatf("%s_word%0d", tag, k), 32'(b.word), 32'(k));
      check($sformatf("%s_data%0d", tag, k), 32'(b.data), 32'(a ^ 16'hA5A5));
      check($sformatf("%s_done%0d", tag, k), 32'(b.done), 32'(k == 7));
    end
    check({tag, "_contig"},
          (rf + 7 < rd_cyc.size()) ? rd_cyc[rf + 7] - rd_cyc[rf] : -1, 7);
  endtask

  initial begin
    bit exp_order[4];
    int t;

    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    clear_mon();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_i_busy", bus.i_busy, 0);
    check("rst_d_busy", bus.d_busy, 0);
    check("rst_i_vld",  bus.i_vld, 0);
    check("rst_d_done", bus.d_done, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b0;
    idle(2);

    // I fill from an unaligned address.
    clear_mon();
    bus.i_addr = 16'h1237;
    bus.i_req  = 1'b1;
    serve("ifill", 1, 0, 100);
    idle(4);
    check("ifill_nrd", rd_addrs.size(), 8);
    check("ifill_nbeat", i_beats.size(), 8);
    check_burst("ifill", 1'b0, 16'h1230, 0, 0);
    check("ifill_d_busy", d_busy_n, 0);
    check("ifill_d_vld", d_beats.size(), 0);
    check("ifill_i_busy_seen", i_busy_n > 0, 1);
    check("ifill_i_busy_off", bus.i_busy, 0);

    // D write-through.
    clear_mon();
    bus.d_addr  = 16'h00A4;
    bus.d_wdata = 16'hBEEF;
    bus.d_we    = 1'b1;
    bus.d_req   = 1'b1;
    serve("dwr", 1, 0, 50);
    bus.d_we = 1'b0;
    idle(4);
    check("dwr_nwr", wr_addrs.size(), 1);
    check("dwr_addr", (wr_addrs.size() > 0) ? 32'(wr_addrs[0]) : 32'hFFFF_FFFF, 32'h00A4);
    check("dwr_data", (wr_data.size() > 0) ? 32'(wr_data[0]) : 32'hFFFF_FFFF, 32'hBEEF);
    check("dwr_done_lat",
          (wr_cyc.size() > 0 && done_cyc.size() > 0) ? done_cyc[0] - wr_cyc[0] : -1, 1);
    check("dwr_no_vld", d_beats.size(), 0);
    check("dwr_no_rd", rd_addrs.size(), 0);

    // Simultaneous requests, two rounds.
    clear_mon();
    bus.i_addr = 16'h2000;
    bus.d_addr = 16'h3000;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    serve("tie1", 2, 0, 200);
    bus.i_addr = 16'h2010;
    bus.d_addr = 16'h3010;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    serve("tie2", 2, 0, 200);
    idle(4);
    exp_order[0] = 1'b1;
    exp_order[1] = 1'b0;
    exp_order[2] = RR ? 1'b0 : 1'b1;
    exp_order[3] = RR ? 1'b1 : 1'b0;
    for (int j = 0; j < 4; j++)
      check($sformatf("tie_order%0d", j),
            (j < done_side.size()) ? 32'(done_side[j]) : 32'hFFFF_FFFF, 32'(exp_order[j]));
    check("tie_first_blk", (rd_addrs.size() > 0) ? 32'(rd_addrs[0]) : 32'hFFFF_FFFF, 32'h3000);
    check("tie_r2_blk", (rd_addrs.size() > 16) ? 32'(rd_addrs[16]) : 32'hFFFF_FFFF,
          RR ? 32'h2010 : 32'h3010);
    check("tie_nrd", rd_addrs.size(), 32);

    // Reset in the middle of an I fill, then a D fill from scratch.
    clear_mon();
    bus.i_addr = 16'h5550;
    bus.i_req  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      sample();
      t++;
    end while (!bus.i_busy && t < 20);
    check("rst_mid_grant", bus.i_busy, 1);
    idle(3);
    check("rst_mid_pre_en", bus.mem_en, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_i_busy", bus.i_busy, 0);
    check("rst_mid_mem_en", bus.mem_en, 0);
    check("rst_mid_mem_addr", bus.mem_addr, 0);
    check("rst_mid_i_vld", bus.i_vld, 0);
    check("rst_mid_i_done", bus.i_done, 0);
    bus.i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    check("rst_mid_no_done", n_dones(1'b0), 0);
    check("rst_mid_no_vld", i_beats.size(), 0);
    clear_mon();
    bus.d_addr = 16'h0440;
    bus.d_we   = 1'b0;
    bus.d_req  = 1'b1;
    serve("rst_dfill", 1, 0, 100);
    idle(4);
    check("rst_dfill_nbeat", d_beats.size(), 8);
    check_burst("rst_dfill", 1'b1, 16'h0440, 0, 0);

    // I request held through done; address changed mid-fill.
    clear_mon();
    bus.i_addr = 16'h6000;
    bus.i_req  = 1'b1;
    idle(3);
    bus.i_addr = 16'h4000;
    serve("b2b", 2, 1, 200);
    idle(4);
    check("b2b_nrd", rd_addrs.size(), 16);
    check_burst("b2b1", 1'b0, 16'h6000, 0, 0);
    check_burst("b2b2", 1'b0, 16'h4000, 8, 8);
    check("b2b_dwell",
          (rd_cyc.size() > 8 && done_cyc.size() > 0) ? rd_cyc[8] - done_cyc[0] : -1, 2);

    // D fill at the top of the address space.
    clear_mon();
    bus.d_addr = 16'hFFF6;
    bus.d_we   = 1'b0;
    bus.d_req  = 1'b1;
    serve("top", 1, 0, 100);
    idle(4);
    check("top_nrd", rd_addrs.size(), 8);
    check_burst("top", 1'b1, 16'hFFF0, 0, 0);
    check("top_i_busy", i_busy_n, 0);

    check("busy_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
